// File: rtl/evr_v1_pkg.sv
// Shared event codes and the FIFO entry layout for the EVR timestamp capture path.
package evr_v1_pkg;
    localparam logic [7:0] EVT_NONE      = 8'h00;
    localparam logic [7:0] EVT_TOD_0     = 8'h70;
    localparam logic [7:0] EVT_TOD_1     = 8'h71;
    localparam logic [7:0] EVT_TOD_LATCH = 8'h7D;

    localparam int ENTRY_W = 72;

    typedef struct packed {
        logic [7:0]  code;
        logic [63:0] timestamp;
    } evtEntry_t;
endpackage

// File: rtl/evr_v1_ts_fifo_ram.sv
// Simple dual-port entry store: synchronous write, registered read with read enable.
module evr_v1_ts_fifo_ram
    import evr_v1_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  evtEntry_t         WrData,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RdAddr,
    output evtEntry_t         RdData
);
    evtEntry_t mem [2**ADDR_W];

    always_ff @(posedge Clock) begin
        if (WrEn) mem[WrAddr] <= WrData;
    end

    // Read register doubles as the show-ahead output, so it only moves on RdEn.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)     RdData <= '0;
        else if (RdEn) RdData <= mem[RdAddr];
    end
endmodule

// File: rtl/evr_v1_event_timestamp_fifo.sv
// Captures {code, TimeStamp} for mask-selected events into a show-ahead FIFO.
module evr_v1_event_timestamp_fifo
    import evr_v1_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DROP_W = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [7:0]          EventStream,
    input  logic [63:0]         TimeStamp,
    input  logic                Enable,
    input  logic                MaskWrEn,
    input  logic [7:0]          MaskAddr,
    input  logic                MaskData,
    input  logic                Clear,
    output logic                RdValid,
    input  logic                RdReady,
    output logic [ENTRY_W-1:0]  RdData,
    output logic [ADDR_W:0]     Level,
    output logic                Overflow,
    output logic [DROP_W-1:0]   DropCount
);
    localparam int DEPTH = 2**ADDR_W;

    logic [255:0]      mask;
    logic              s1Hit;
    evtEntry_t         s1Entry;
    logic [ADDR_W-1:0] wrPtr, rdPtr;
    logic [ADDR_W:0]   memCount;
    logic              outValid;
    logic              pop, full, push, drop, load;
    evtEntry_t         ramRd;

    // memCount tracks entries still in RAM; the output register adds one more.
    assign Level   = memCount + {{ADDR_W{1'b0}}, outValid};
    assign full    = (Level == (ADDR_W+1)'(DEPTH));
    assign pop     = outValid & RdReady;
    assign push    = s1Hit & (~full | pop) & ~Clear;
    assign drop    = s1Hit & full & ~pop & ~Clear;
    assign load    = (memCount != '0) & (~outValid | pop) & ~Clear;
    assign RdValid = outValid;
    assign RdData  = ramRd;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)         mask <= '0;
        else if (MaskWrEn) mask[MaskAddr] <= MaskData;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1Hit     <= 1'b0;
            s1Entry   <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            memCount  <= '0;
            outValid  <= 1'b0;
            Overflow  <= 1'b0;
            DropCount <= '0;
        end else if (Clear) begin
            s1Hit     <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            memCount  <= '0;
            outValid  <= 1'b0;
            Overflow  <= 1'b0;
            DropCount <= '0;
        end else begin
            s1Hit   <= Enable & mask[EventStream] & (EventStream != EVT_NONE);
            s1Entry <= '{code: EventStream, timestamp: TimeStamp};
            if (push) wrPtr <= wrPtr + 1'b1;
            if (load) rdPtr <= rdPtr + 1'b1;
            memCount <= memCount + (ADDR_W+1)'(push) - (ADDR_W+1)'(load);
            if (load)     outValid <= 1'b1;
            else if (pop) outValid <= 1'b0;
            if (drop) begin
                Overflow <= 1'b1;
                if (DropCount != '1) DropCount <= DropCount + DROP_W'(1);
            end
        end
    end

    evr_v1_ts_fifo_ram #(.ADDR_W(ADDR_W)) uRam (
        .Clock  (Clock),
        .Reset  (Reset),
        .WrEn   (push),
        .WrAddr (wrPtr),
        .WrData (s1Entry),
        .RdEn   (load),
        .RdAddr (rdPtr),
        .RdData (ramRd)
    );
endmodule

// File: tb/tb_evr_v1_event_timestamp_fifo.sv
// Directed plus randomized checks of the timestamp FIFO against a queue-based model.
module tb_evr_v1_event_timestamp_fifo;
    localparam int ADDR_W = 3;
    localparam int DROP_W = 16;
    localparam int DEPTH  = 2**ADDR_W;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic [7:0]        EventStream = '0;
    logic [63:0]       TimeStamp = '0;
    logic              Enable = 1'b0;
    logic              MaskWrEn = 1'b0;
    logic [7:0]        MaskAddr = '0;
    logic              MaskData = 1'b0;
    logic              Clear = 1'b0;
    logic              RdValid;
    logic              RdReady = 1'b0;
    logic [71:0]       RdData;
    logic [ADDR_W:0]   Level;
    logic              Overflow;
    logic [DROP_W-1:0] DropCount;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mask image, one-deep capture stage, entry queue, drop stats.
    bit [255:0]        mMask = '0;
    bit                mHit = 1'b0;
    logic [71:0]       mEnt = '0;
    logic [71:0]       q[$];
    bit                mOvf = 1'b0;
    logic [DROP_W-1:0] mDrop = '0;

    always #5 Clock = ~Clock;

    evr_v1_event_timestamp_fifo #(.ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
        .Clock(Clock), .Reset(Reset), .EventStream(EventStream), .TimeStamp(TimeStamp),
        .Enable(Enable), .MaskWrEn(MaskWrEn), .MaskAddr(MaskAddr), .MaskData(MaskData),
        .Clear(Clear), .RdValid(RdValid), .RdReady(RdReady), .RdData(RdData),
        .Level(Level), .Overflow(Overflow), .DropCount(DropCount)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mMask = '0;
        mHit  = 1'b0;
        mOvf  = 1'b0;
        mDrop = '0;
    endtask

    task automatic tick();
        bit pop, hitNow;
        pop    = RdValid & RdReady;
        hitNow = Enable & mMask[EventStream] & (EventStream != 8'h00);
        @(posedge Clock);
        if (Clear) begin
            q.delete();
            mOvf  = 1'b0;
            mDrop = '0;
            mHit  = 1'b0;
        end else begin
            if (mHit) begin
                if (q.size() < DEPTH || pop) q.push_back(mEnt);
                else begin
                    mOvf = 1'b1;
                    if (mDrop != '1) mDrop++;
                end
            end
            if (pop) void'(q.pop_front());
            mHit = hitNow;
            mEnt = {EventStream, TimeStamp};
        end
        if (MaskWrEn) mMask[MaskAddr] = MaskData;
        #1;
        TimeStamp = TimeStamp + 64'd1;
        chk("level", 72'(Level), 72'(q.size()));
        chk("overflow", 72'(Overflow), 72'(mOvf));
        chk("dropcount", 72'(DropCount), 72'(mDrop));
        if (q.size() == 0) chk("valid_empty", 72'(RdValid), 72'd0);
        if (RdValid && q.size() > 0) chk("head", RdData, q[0]);
    endtask

    task automatic setMask(input logic [7:0] code, input logic val);
        MaskWrEn = 1'b1; MaskAddr = code; MaskData = val;
        tick();
        MaskWrEn = 1'b0;
    endtask

    task automatic inject(input logic [7:0] code);
        EventStream = code;
        tick();
        EventStream = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drainAll();
        RdReady = 1'b1;
        idle(DEPTH + 4);
        RdReady = 1'b0;
    endtask

    initial begin
        logic [63:0] ts0;
        logic [7:0]  codes [3];
        codes[0] = 8'h28; codes[1] = 8'h7D; codes[2] = 8'h28;

        // Reset values
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_valid", 72'(RdValid), 72'd0);
        chk("rst_data", RdData, 72'd0);
        chk("rst_level", 72'(Level), 72'd0);
        chk("rst_ovf", 72'(Overflow), 72'd0);
        chk("rst_drop", 72'(DropCount), 72'd0);
        Reset = 1'b0;
        idle(2);

        // Single capture and latency
        Enable = 1'b1;
        setMask(8'h28, 1'b1);
        TimeStamp = 64'h0000_1234_0000_0010;
        inject(8'h28);
        tick();
        chk("lat_n2_valid", 72'(RdValid), 72'd0);
        tick();
        chk("lat_n3_valid", 72'(RdValid), 72'd1);
        chk("lat_n3_data", RdData, 72'h28_0000_1234_0000_0010);
        chk("lat_n3_level", 72'(Level), 72'd1);
        inject(8'h29);
        inject(8'h00);
        idle(4);
        chk("unmasked_level", 72'(Level), 72'd1);
        drainAll();

        // Consecutive events, ordered drain at one per cycle
        setMask(8'h7D, 1'b1);
        ts0 = TimeStamp;
        for (int i = 0; i < 3; i++) inject(codes[i]);
        idle(4);
        chk("burst_level", 72'(Level), 72'd3);
        RdReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("burst_valid", 72'(RdValid), 72'd1);
            chk("burst_data", RdData, {codes[i], ts0 + 64'(i)});
            tick();
        end
        RdReady = 1'b0;
        chk("burst_empty", 72'(RdValid), 72'd0);
        idle(2);

        // Overflow with ten events into eight slots
        for (int i = 0; i < 10; i++) inject(8'h28);
        idle(4);
        chk("ovf_level", 72'(Level), 72'd8);
        chk("ovf_flag", 72'(Overflow), 72'd1);
        chk("ovf_drop", 72'(DropCount), 72'd2);

        // Push while full but popping in the same cycle
        inject(8'h28);
        RdReady = 1'b1;
        tick();
        RdReady = 1'b0;
        idle(3);
        chk("fullpop_level", 72'(Level), 72'd8);
        chk("fullpop_drop", 72'(DropCount), 72'd2);

        // Stall stability for 20 cycles
        ts0 = RdData[63:0];
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_data", RdData, {8'h28, ts0});
        end

        // Clear
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("clr_level", 72'(Level), 72'd0);
        chk("clr_valid", 72'(RdValid), 72'd0);
        chk("clr_ovf", 72'(Overflow), 72'd0);
        chk("clr_drop", 72'(DropCount), 72'd0);
        ts0 = TimeStamp;
        inject(8'h28);
        idle(2);
        chk("clr_mask_kept", RdData, {8'h28, ts0});
        drainAll();

        // Mask bit removal
        setMask(8'h28, 1'b0);
        inject(8'h28);
        idle(4);
        chk("unmask_level", 72'(Level), 72'd0);

        // Async reset mid-drain
        setMask(8'h28, 1'b1);
        for (int i = 0; i < 6; i++) inject(8'h28);
        idle(3);
        RdReady = 1'b1;
        tick();
        RdReady = 1'b0;
        chk("pre_rst_level", 72'(Level), 72'd5);
        #2 Reset = 1'b1;
        #1;
        modelReset();
        chk("arst_valid", 72'(RdValid), 72'd0);
        chk("arst_data", RdData, 72'd0);
        chk("arst_level", 72'(Level), 72'd0);
        chk("arst_ovf", 72'(Overflow), 72'd0);
        chk("arst_drop", 72'(DropCount), 72'd0);
        #1 Reset = 1'b0;
        idle(1);
        setMask(8'h28, 1'b1);
        ts0 = TimeStamp;
        inject(8'h28);
        tick();
        chk("post_rst_n2", 72'(RdValid), 72'd0);
        tick();
        chk("post_rst_n3", 72'(RdValid), 72'd1);
        chk("post_rst_data", RdData, {8'h28, ts0});
        drainAll();

        // Randomized traffic, mask writes and occasional clears
        setMask(8'h70, 1'b1);
        setMask(8'h71, 1'b1);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    EventStream = 8'h00;
                2:       EventStream = 8'h28;
                3:       EventStream = 8'h70;
                4:       EventStream = 8'h71;
                5:       EventStream = 8'h7D;
                6:       EventStream = 8'h29;
                default: EventStream = 8'($urandom);
            endcase
            TimeStamp = {$urandom, $urandom};
            Enable    = ($urandom_range(0, 9) != 0);
            RdReady   = ($urandom_range(0, 2) == 0);
            Clear     = ($urandom_range(0, 63) == 0);
            MaskWrEn  = ($urandom_range(0, 15) == 0);
            MaskAddr  = ($urandom_range(0, 1) == 0) ? 8'h28 : 8'($urandom);
            MaskData  = 1'($urandom);
            tick();
        end
        EventStream = 8'h00;
        MaskWrEn = 1'b0;
        Clear = 1'b0;
        Enable = 1'b1;
        drainAll();
        chk("final_level", 72'(Level), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
